// File: rtl/xrun_seq_pkg.sv
// rtl/xrun_seq_pkg.sv - shared widths, state encoding and control address for the run sequencer
package xrun_seq_pkg;

  localparam int DATA_W         = 32;
  localparam int NMEM_W         = 2;
  localparam int MEM_ADDR_W     = 8;
  localparam int ADDR_W         = NMEM_W + MEM_ADDR_W + 1;
  localparam int SEL_W          = 4;
  localparam int REP_W          = 8;
  localparam int JOB_W          = SEL_W + REP_W;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_GUARD      = 2;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_WAIT = 3'd3,
    S_POLL = 3'd4
  } state_t;

  // Address MSB selects the engine control register; all other bits zero.
  function automatic logic [ADDR_W-1:0] ctrl_addr();
    return {1'b1, {(ADDR_W-1){1'b0}}};
  endfunction

endpackage

// File: rtl/xrun_seq_fifo.sv
// rtl/xrun_seq_fifo.sv - synchronous job queue with flush, full and empty
module xrun_seq_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/xrun_seq.sv
// rtl/xrun_seq.sv - job sequencer: load config slot, start run, poll done, arbitrate engine port
module xrun_seq
  import xrun_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int GUARD      = DEF_GUARD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [SEL_W-1:0]  job_sel,
  input  logic [REP_W-1:0]  job_rep,
  input  logic              abort,
  input  logic              host_valid,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_rdata,
  output logic [DATA_W-1:0] host_wdata,
  output logic              host_ready,
  output logic              conf_ld,
  output logic [SEL_W-1:0]  conf_sel,
  output logic              eng_valid,
  output logic              eng_we,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [DATA_W-1:0] eng_rdata,
  input  logic [DATA_W-1:0] eng_wdata,
  output logic              busy,
  output logic [15:0]       jobs_done,
  output logic              irq
);

  localparam int GW = $clog2(GUARD + 1);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ctrl_addr();

  state_t            state, state_n;
  logic [SEL_W-1:0]  sel_q;
  logic [REP_W-1:0]  rep_q;
  logic [GW-1:0]     guard_q;
  logic [15:0]       done_q;

  logic              push, pop, full, empty;
  logic [JOB_W-1:0]  fifo_rdata;
  logic              done_bit;
  logic              rep_dec, job_fin;
  logic              seq_valid, seq_we;
  logic [ADDR_W-1:0] seq_addr;
  logic [DATA_W-1:0] seq_data;

  // A push that coincides with abort is discarded along with the flush.
  assign push      = job_valid & ~full & ~abort;
  assign job_ready = ~full;
  assign done_bit  = eng_wdata[0];

  xrun_seq_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .wdata ({job_sel, job_rep}),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_n   = state;
    pop       = 1'b0;
    conf_ld   = 1'b0;
    seq_valid = 1'b0;
    seq_we    = 1'b0;
    seq_addr  = '0;
    seq_data  = '0;
    rep_dec   = 1'b0;
    job_fin   = 1'b0;
    irq       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty && !abort) begin
          pop     = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: begin
        conf_ld = 1'b1;
        state_n = S_RUN;
      end
      S_RUN: begin
        seq_valid = 1'b1;
        seq_we    = 1'b1;
        seq_addr  = CTRL_ADDR;
        seq_data  = DATA_W'(1);
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (guard_q == GW'(GUARD - 1)) state_n = S_POLL;
      end
      S_POLL: begin
        seq_valid = 1'b1;
        seq_addr  = CTRL_ADDR;
        if (done_bit) begin
          if (rep_q != '0 && !abort) begin
            rep_dec = 1'b1;
            state_n = S_RUN;
          end else begin
            job_fin = 1'b1;
            irq     = (empty | abort) & ~push;
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      sel_q   <= '0;
      rep_q   <= '0;
      guard_q <= '0;
      done_q  <= '0;
    end else begin
      state <= state_n;
      if (pop) sel_q <= fifo_rdata[JOB_W-1:REP_W];
      if (abort)        rep_q <= '0;
      else if (pop)     rep_q <= fifo_rdata[REP_W-1:0];
      else if (rep_dec) rep_q <= rep_q - REP_W'(1);
      if (state == S_RUN)       guard_q <= '0;
      else if (state == S_WAIT) guard_q <= guard_q + GW'(1);
      if (job_fin) done_q <= done_q + 16'd1;
    end
  end

  // The host owns the engine port only while nothing is queued or running.
  assign host_ready = (state == S_IDLE) && empty;
  assign eng_valid  = host_ready ? host_valid : seq_valid;
  assign eng_we     = host_ready ? host_we    : seq_we;
  assign eng_addr   = host_ready ? host_addr  : seq_addr;
  assign eng_rdata  = host_ready ? host_rdata : seq_data;
  assign host_wdata = host_ready ? eng_wdata  : '0;

  assign conf_sel  = sel_q;
  assign busy      = (state != S_IDLE) | ~empty;
  assign jobs_done = done_q;

endmodule

// File: tb/tb_xrun_seq.sv
// tb/tb_xrun_seq.sv - directed self-checking bench for the run sequencer
module tb_xrun_seq;
  import xrun_seq_pkg::*;

  localparam logic [ADDR_W-1:0] CTRL = 11'h400;
  localparam logic [ADDR_W-1:0] MEM1_A7 = 11'h107;

  logic              clk = 1'b0;
  logic              rst;
  logic              job_valid, job_ready, abort;
  logic [SEL_W-1:0]  job_sel;
  logic [REP_W-1:0]  job_rep;
  logic              host_valid, host_we, host_ready;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_rdata, host_wdata;
  logic              conf_ld;
  logic [SEL_W-1:0]  conf_sel;
  logic              eng_valid, eng_we;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_rdata, eng_wdata;
  logic              busy, irq;
  logic [15:0]       jobs_done;

  int n_cmp = 0;
  int n_bad = 0;

  int since_run = 0;
  int done_after = 5;
  int conf_cnt = 0, run_cnt = 0, run_bad = 0, poll_cnt = 0, irq_cnt = 0;
  logic [SEL_W-1:0] sel_log [64];
  int b_conf, b_run, b_poll, b_irq;

  xrun_seq dut (
    .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
    .job_sel(job_sel), .job_rep(job_rep), .abort(abort),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr),
    .host_rdata(host_rdata), .host_wdata(host_wdata), .host_ready(host_ready),
    .conf_ld(conf_ld), .conf_sel(conf_sel), .eng_valid(eng_valid), .eng_we(eng_we),
    .eng_addr(eng_addr), .eng_rdata(eng_rdata), .eng_wdata(eng_wdata),
    .busy(busy), .jobs_done(jobs_done), .irq(irq)
  );

  always #5 clk = ~clk;

  // Engine model: done reads 1 on the done_after-th poll following a run write.
  assign eng_wdata = (!eng_valid || eng_we) ? 32'h0 :
                     (eng_addr == CTRL) ? 32'(since_run + 1 >= done_after) : 32'h5A5A_0000;

  always @(posedge clk) begin
    if (!rst) begin
      if (eng_valid && eng_we && eng_addr == CTRL) since_run <= 0;
      else if (eng_valid && !eng_we && eng_addr == CTRL) since_run <= since_run + 1;
      if (conf_ld) begin
        conf_cnt <= conf_cnt + 1;
        sel_log[conf_cnt & 63] <= conf_sel;
      end
      if (!host_ready && eng_valid && eng_we) begin
        run_cnt <= run_cnt + 1;
        if (eng_rdata != 32'd1 || eng_addr != CTRL) run_bad <= run_bad + 1;
      end
      if (!host_ready && eng_valid && !eng_we) poll_cnt <= poll_cnt + 1;
      if (irq) irq_cnt <= irq_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_job(input logic [SEL_W-1:0] s, input logic [REP_W-1:0] r);
    job_valid = 1'b1;
    job_sel   = s;
    job_rep   = r;
    @(posedge clk);
    @(negedge clk);
    job_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'b0, busy}, 0);
  endtask

  task automatic snap();
    b_conf = conf_cnt;
    b_run  = run_cnt;
    b_poll = poll_cnt;
    b_irq  = irq_cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; job_valid = 0; job_sel = 0; job_rep = 0; abort = 0;
    host_valid = 0; host_we = 0; host_addr = 0; host_rdata = 0;
    repeat (2) @(negedge clk);
    check("rst_job_ready", {31'b0, job_ready}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_jobs_done", {16'b0, jobs_done}, 0);
    check("rst_conf_ld", {31'b0, conf_ld}, 0);
    check("rst_irq", {31'b0, irq}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single job sel=3 rep=0, done on 5th poll, with cycle-exact start sequence
    done_after = 5;
    snap();
    push_job(4'd3, 8'd0);
    check("t1_n0_conf_ld", {31'b0, conf_ld}, 0);
    check("t1_n0_busy", {31'b0, busy}, 1);
    check("t1_n0_host_ready", {31'b0, host_ready}, 0);
    @(negedge clk);
    check("t1_conf_ld", {31'b0, conf_ld}, 1);
    check("t1_conf_sel", {28'b0, conf_sel}, 3);
    @(negedge clk);
    check("t1_run_valid", {31'b0, eng_valid}, 1);
    check("t1_run_we", {31'b0, eng_we}, 1);
    check("t1_run_addr", {21'b0, eng_addr}, 32'h400);
    check("t1_run_data", eng_rdata, 1);
    @(negedge clk);
    check("t1_wait_valid", {31'b0, eng_valid}, 0);
    repeat (2) @(negedge clk);
    check("t1_poll_valid", {31'b0, eng_valid}, 1);
    check("t1_poll_we", {31'b0, eng_we}, 0);
    wait_idle(200);
    check("t1_conf_cnt", conf_cnt - b_conf, 1);
    check("t1_run_cnt", run_cnt - b_run, 1);
    check("t1_poll_cnt", poll_cnt - b_poll, 5);
    check("t1_irq_cnt", irq_cnt - b_irq, 1);
    check("t1_jobs_done", {16'b0, jobs_done}, 1);
    check("t1_run_bad", run_bad, 0);

    // Repeat count 2: three runs, one load, one completion
    done_after = 2;
    snap();
    push_job(4'd5, 8'd2);
    wait_idle(300);
    check("t2_conf_cnt", conf_cnt - b_conf, 1);
    check("t2_run_cnt", run_cnt - b_run, 3);
    check("t2_poll_cnt", poll_cnt - b_poll, 6);
    check("t2_irq_cnt", irq_cnt - b_irq, 1);
    check("t2_jobs_done", {16'b0, jobs_done}, 2);

    // Five back-to-back pushes into a 4-deep queue
    done_after = 3;
    snap();
    push_job(4'd1, 8'd0);
    push_job(4'd2, 8'd0);
    push_job(4'd3, 8'd0);
    push_job(4'd4, 8'd0);
    push_job(4'd6, 8'd0);
    check("t3_job_ready_full", {31'b0, job_ready}, 0);
    wait_idle(1000);
    check("t3_conf_cnt", conf_cnt - b_conf, 5);
    check("t3_sel0", {28'b0, sel_log[(b_conf + 0) & 63]}, 1);
    check("t3_sel1", {28'b0, sel_log[(b_conf + 1) & 63]}, 2);
    check("t3_sel2", {28'b0, sel_log[(b_conf + 2) & 63]}, 3);
    check("t3_sel3", {28'b0, sel_log[(b_conf + 3) & 63]}, 4);
    check("t3_sel4", {28'b0, sel_log[(b_conf + 4) & 63]}, 6);
    check("t3_irq_cnt", irq_cnt - b_irq, 1);
    check("t3_jobs_done", {16'b0, jobs_done}, 7);
    check("t3_job_ready", {31'b0, job_ready}, 1);

    // Host pass-through while idle and empty
    host_valid = 1; host_we = 1; host_addr = MEM1_A7; host_rdata = 32'hA5;
    #1;
    check("t4_host_ready", {31'b0, host_ready}, 1);
    check("t4_eng_valid", {31'b0, eng_valid}, 1);
    check("t4_eng_we", {31'b0, eng_we}, 1);
    check("t4_eng_addr", {21'b0, eng_addr}, 32'h107);
    check("t4_eng_rdata", eng_rdata, 32'hA5);
    host_we = 0;
    #1;
    check("t4_host_read", host_wdata, 32'h5A5A_0000);
    host_valid = 0;
    @(negedge clk);

    // Same host access during POLL is not forwarded
    done_after = 3;
    push_job(4'd9, 8'd0);
    repeat (5) @(negedge clk);
    host_valid = 1; host_we = 1; host_addr = MEM1_A7; host_rdata = 32'hA5;
    #1;
    check("t4_poll_host_ready", {31'b0, host_ready}, 0);
    check("t4_poll_eng_we", {31'b0, eng_we}, 0);
    check("t4_poll_eng_addr", {21'b0, eng_addr}, 32'h400);
    check("t4_poll_eng_rdata", eng_rdata, 0);
    check("t4_poll_host_wdata", host_wdata, 0);
    host_valid = 0; host_we = 0; host_addr = 0; host_rdata = 0;
    wait_idle(200);
    check("t4_jobs_done", {16'b0, jobs_done}, 8);

    // Abort during WAIT with two jobs queued behind a rep=3 job
    done_after = 2;
    snap();
    push_job(4'd7, 8'd3);
    push_job(4'd8, 8'd0);
    push_job(4'd10, 8'd0);
    @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    wait_idle(300);
    check("t5_conf_cnt", conf_cnt - b_conf, 1);
    check("t5_run_cnt", run_cnt - b_run, 1);
    check("t5_poll_cnt", poll_cnt - b_poll, 2);
    check("t5_irq_cnt", irq_cnt - b_irq, 1);
    check("t5_jobs_done", {16'b0, jobs_done}, 9);
    check("t5_job_ready", {31'b0, job_ready}, 1);

    // Reset asserted in POLL, then a normal job
    done_after = 100;
    push_job(4'd2, 8'd0);
    repeat (5) @(negedge clk);
    check("t6_in_poll", {31'b0, eng_valid}, 1);
    rst = 1;
    @(negedge clk);
    check("t6_rst_busy", {31'b0, busy}, 0);
    check("t6_rst_eng_valid", {31'b0, eng_valid}, 0);
    check("t6_rst_jobs_done", {16'b0, jobs_done}, 0);
    check("t6_rst_job_ready", {31'b0, job_ready}, 1);
    check("t6_rst_irq", {31'b0, irq}, 0);
    check("t6_rst_conf_ld", {31'b0, conf_ld}, 0);
    rst = 0;
    @(negedge clk);
    done_after = 1;
    snap();
    push_job(4'd4, 8'd1);
    wait_idle(200);
    check("t6_conf_cnt", conf_cnt - b_conf, 1);
    check("t6_sel", {28'b0, sel_log[b_conf & 63]}, 4);
    check("t6_run_cnt", run_cnt - b_run, 2);
    check("t6_irq_cnt", irq_cnt - b_irq, 1);
    check("t6_jobs_done", {16'b0, jobs_done}, 1);
    check("t6_run_bad", run_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
